wb_accel_regbank: RTL and testbench
===================================

WB_ACCEL_REGBANK -- requirements
Module: wb_accel_regbank

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3003_0000, meaning the Wishbone base address of the register window.
REQ-002 SHALL have parameter NUM_CH, default 2, range 1..8, meaning the number of input/output data channels.
REQ-003 SHALL have parameter DATA_W, default 20, range 1..32, meaning the width of each channel register.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone cycle, strobe, write-enable.
REQ-007 wishbone_address  input  32  byte address; wbs_sel_i  input  4  byte lanes; wbs_dat_i  input  32  write data.
REQ-008 wbs_dat_o  output  32  read data; wbs_ack_o  output  1  acknowledge.
REQ-009 core_req_valid  output  1; core_req_ready  input  1; core_in  output  NUM_CH*DATA_W  (channel n at bits [n*DATA_W +: DATA_W]).
REQ-010 core_rsp_valid  input  1; core_rsp_data  input  NUM_CH*DATA_W; irq  output  1.

Function
REQ-011 SHALL decode word offsets: 0x00 CTRL, 0x04 STATUS, 0x10+4n CH_IN[n], 0x30+4n CH_OUT[n] for n < NUM_CH.
REQ-012 CTRL: bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN (R/W); STATUS: bit0 BUSY (RO), bit1 DONE (W1C), bit2 OVERRUN (W1C).
REQ-013 Access: on rising edge where cyc&&stb&&!ack, SHALL register wbs_dat_o, apply the write, and assert wbs_ack_o for exactly one cycle; ack SHALL deassert the following cycle, giving a minimum of 2 cycles per access.
REQ-014 Writes SHALL apply only byte lanes with wbs_sel_i set; bits at or above DATA_W SHALL be ignored on write and read as 0.
REQ-015 Unmapped offsets and channels n >= NUM_CH SHALL ack with wbs_dat_o = 0 and no side effect.
REQ-016 Writes to CH_OUT SHALL be ignored; CH_IN writes while BUSY=1 SHALL be dropped (still acked).
REQ-017 FSM states IDLE, REQ, WAIT: IDLE->REQ on START write; REQ->WAIT on core_req_valid&&core_req_ready; WAIT->IDLE on core_rsp_valid.
REQ-018 core_req_valid SHALL be 1 exactly in REQ; core_in SHALL equal CH_IN contents and be stable while core_req_valid=1.
REQ-019 BUSY SHALL be 1 in REQ and WAIT; core_rsp_valid outside WAIT SHALL be ignored.
REQ-020 On WAIT->IDLE, all CH_OUT SHALL capture core_rsp_data and DONE SHALL set in the same edge.
REQ-021 START while BUSY=1 SHALL be ignored and SHALL set OVERRUN.
REQ-022 DONE set and DONE W1C on the same edge: set SHALL win; same rule for OVERRUN.
REQ-023 irq SHALL be registered, equal to IRQ_EN && DONE, one cycle after DONE changes.
REQ-024 START write in IDLE SHALL enter REQ on the ack edge; a read of STATUS in that access returns the pre-write value.

Reset
REQ-025 When rst_n=0 at a rising edge: FSM=IDLE, CTRL, STATUS, CH_IN, CH_OUT, wbs_dat_o, wbs_ack_o, core_req_valid, irq all SHALL become 0.
REQ-026 Reset mid-operation SHALL abandon the transaction; a core_rsp_valid arriving after reset release SHALL be ignored (FSM in IDLE).

Structure
REQ-027 A shared package SHALL hold register offsets, CTRL/STATUS bit indices and the FSM state enumeration.
REQ-028 One sub-module wb_byte_lane_reg (DATA_W-wide register with byte-lane write and synchronous clear) SHALL be instantiated per CH_IN channel.

Verification
REQ-029 Reset then read every register -> all return 0, ack one cycle after request, irq=0.
REQ-030 Write CH_IN[0]=0x12345 sel=4'b0011 (DATA_W=20) -> reads 0x02345; write sel=4'b1111 value 0xFFFFFFFF -> reads 0xFFFFF.
REQ-031 Write CH_IN[0]=5, CH_IN[1]=7, IRQ_EN=1, START; core ready after 3 cycles, rsp 4 cycles later with data {8,6} -> core_in={7,5} stable, CH_OUT={6,8}, DONE=1, irq=1 next cycle.
REQ-032 START during WAIT and CH_IN[0] write 9 -> OVERRUN=1, CH_IN[0] unchanged, transaction completes normally.
REQ-033 W1C DONE on the same edge as core_rsp_valid -> DONE reads 1; subsequent W1C -> DONE=0, irq=0.
REQ-034 Assert rst_n=0 for one cycle while in REQ, then pulse core_rsp_valid -> core_req_valid=0, BUSY=0, DONE=0, CH_OUT=0.

Source files
------------

// File: rtl/wb_accel_regbank_pkg.sv
// Shared definitions for the Wishbone accelerator register bank:
// register offsets, CTRL/STATUS bit positions and the handshake FSM states.
package wb_accel_regbank_pkg;

  localparam int unsigned WB_W = 32;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CH_IN  = 8'h10;
  localparam logic [7:0] OFF_CH_OUT = 8'h30;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_IRQ_EN  = 1;
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_DONE    = 1;
  localparam int unsigned STAT_OVERRUN = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Byte offset of channel n within a channel register block
  function automatic logic [7:0] ch_off(input logic [7:0] base, input int unsigned n);
    return base + 8'(4 * n);
  endfunction

endpackage

// File: rtl/wb_byte_lane_reg.sv
// DATA_W-wide register written per Wishbone byte lane, with synchronous clear.
module wb_byte_lane_reg #(
  parameter int unsigned DATA_W = 20
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        we,
  input  logic [((DATA_W+7)/8)-1:0]   sel,
  input  logic [DATA_W-1:0]           wdat,
  output logic [DATA_W-1:0]           q
);

  logic [DATA_W-1:0] mask;

  for (genvar i = 0; i < DATA_W; i++) begin : g_mask
    assign mask[i] = sel[i/8];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (we) begin
      q <= (q & ~mask) | (wdat & mask);
    end
  end

endmodule

// File: rtl/wb_accel_regbank.sv
// Wishbone register window fronting a valid/ready accelerator core:
// CH_IN operands, START/IRQ control, BUSY/DONE/OVERRUN status, CH_OUT results.
module wb_accel_regbank
  import wb_accel_regbank_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3003_0000,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DATA_W    = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_we_i,
  input  logic [31:0]                wishbone_address,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_dat_i,
  output logic [31:0]                wbs_dat_o,
  output logic                       wbs_ack_o,
  output logic                       core_req_valid,
  input  logic                       core_req_ready,
  output logic [NUM_CH*DATA_W-1:0]   core_in,
  input  logic                       core_rsp_valid,
  input  logic [NUM_CH*DATA_W-1:0]   core_rsp_data,
  output logic                       irq
);

  localparam int unsigned NB = (DATA_W + 7) / 8;

  state_e state_q, state_d;

  logic              ack_q;
  logic [WB_W-1:0]   dat_q;
  logic              irq_en_q;
  logic              done_q;
  logic              ovr_q;
  logic              req_valid_q;
  logic              irq_q;
  logic [DATA_W-1:0] ch_in_q  [NUM_CH];
  logic [DATA_W-1:0] ch_out_q [NUM_CH];

  logic              access;
  logic              wr;
  logic              in_win;
  logic [7:0]        off;
  logic              busy;
  logic              hit_ctrl;
  logic              hit_status;
  logic [NUM_CH-1:0] hit_in;
  logic [NUM_CH-1:0] hit_out;
  logic [WB_W-1:0]   rdata;
  logic              start_wr;
  logic              w1c_done;
  logic              w1c_ovr;
  logic              rsp_fire;

  // Lanes and data bits above DATA_W carry nothing for channel registers
  logic unused_in;
  assign unused_in = ^{wbs_sel_i, wbs_dat_i};

  assign access = wbs_cyc_i && wbs_stb_i && !ack_q;
  assign wr     = access && wbs_we_i;
  assign in_win = (wishbone_address[31:8] == BASE_ADDR[31:8]);
  assign off    = wishbone_address[7:0];
  assign busy   = (state_q != ST_IDLE);

  assign hit_ctrl   = in_win && (off == OFF_CTRL);
  assign hit_status = in_win && (off == OFF_STATUS);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_dec
    assign hit_in[n]  = in_win && (off == ch_off(OFF_CH_IN, n));
    assign hit_out[n] = in_win && (off == ch_off(OFF_CH_OUT, n));
  end

  assign start_wr = wr && hit_ctrl && wbs_sel_i[0] && wbs_dat_i[CTRL_START];
  assign w1c_done = wr && hit_status && wbs_sel_i[0] && wbs_dat_i[STAT_DONE];
  assign w1c_ovr  = wr && hit_status && wbs_sel_i[0] && wbs_dat_i[STAT_OVERRUN];
  assign rsp_fire = (state_q == ST_WAIT) && core_rsp_valid;

  // Read mux; unmapped offsets fall through to zero
  always_comb begin
    rdata = '0;
    if (hit_ctrl) begin
      rdata[CTRL_IRQ_EN] = irq_en_q;
    end
    if (hit_status) begin
      rdata[STAT_BUSY]    = busy;
      rdata[STAT_DONE]    = done_q;
      rdata[STAT_OVERRUN] = ovr_q;
    end
    for (int n = 0; n < NUM_CH; n++) begin
      if (hit_in[n]) begin
        rdata = WB_W'(ch_in_q[n]);
      end
      if (hit_out[n]) begin
        rdata = WB_W'(ch_out_q[n]);
      end
    end
  end

  // Handshake FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_wr)       state_d = ST_REQ;
      ST_REQ:  if (core_req_ready) state_d = ST_WAIT;
      ST_WAIT: if (core_rsp_valid) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= (state_d == ST_REQ);
    end
  end

  // Single-cycle ack; read data captured on the access edge (pre-write view)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= access;
      if (access) begin
        dat_q <= rdata;
      end
    end
  end

  // Control/status; hardware set beats software clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr && hit_ctrl && wbs_sel_i[0]) begin
        irq_en_q <= wbs_dat_i[CTRL_IRQ_EN];
      end
      if (rsp_fire) begin
        done_q <= 1'b1;
      end else if (w1c_done) begin
        done_q <= 1'b0;
      end
      if (start_wr && busy) begin
        ovr_q <= 1'b1;
      end else if (w1c_ovr) begin
        ovr_q <= 1'b0;
      end
      irq_q <= irq_en_q && done_q;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    wb_byte_lane_reg #(
      .DATA_W (DATA_W)
    ) u_ch_in (
      .clk  (clk),
      .clr  (!rst_n),
      .we   (wr && hit_in[n] && !busy),
      .sel  (wbs_sel_i[NB-1:0]),
      .wdat (wbs_dat_i[DATA_W-1:0]),
      .q    (ch_in_q[n])
    );

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        ch_out_q[n] <= '0;
      end else if (rsp_fire) begin
        ch_out_q[n] <= core_rsp_data[n*DATA_W +: DATA_W];
      end
    end

    assign core_in[n*DATA_W +: DATA_W] = ch_in_q[n];
  end

  assign wbs_ack_o      = ack_q;
  assign wbs_dat_o      = dat_q;
  assign core_req_valid = req_valid_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_wb_accel_regbank.sv
// Self-checking bench: register-level model compared every cycle, plus directed literal checks.
module tb_wb_accel_regbank;

  localparam logic [31:0] BASE = 32'h3003_0000;
  localparam int NC = 2;
  localparam int DW = 20;

  logic        clk;
  logic        rst_n;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [31:0] wishbone_address;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        core_req_valid;
  logic        core_req_ready;
  logic [NC*DW-1:0] core_in;
  logic        core_rsp_valid;
  logic [NC*DW-1:0] core_rsp_data;
  logic        irq;

  int errors = 0;
  int checks = 0;

  wb_accel_regbank #(
    .BASE_ADDR (BASE),
    .NUM_CH    (NC),
    .DATA_W    (DW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wbs_cyc_i        (wbs_cyc_i),
    .wbs_stb_i        (wbs_stb_i),
    .wbs_we_i         (wbs_we_i),
    .wishbone_address (wishbone_address),
    .wbs_sel_i        (wbs_sel_i),
    .wbs_dat_i        (wbs_dat_i),
    .wbs_dat_o        (wbs_dat_o),
    .wbs_ack_o        (wbs_ack_o),
    .core_req_valid   (core_req_valid),
    .core_req_ready   (core_req_ready),
    .core_in          (core_in),
    .core_rsp_valid   (core_rsp_valid),
    .core_rsp_data    (core_rsp_data),
    .irq              (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register-level model: phase 0 idle, 1 requesting, 2 awaiting response
  int          m_phase;
  logic        m_irq_en, m_done, m_ovr, m_ack, m_irq, started;
  logic [31:0] m_dat;
  logic [DW-1:0] m_in [NC];
  logic [DW-1:0] m_out [NC];

  initial started = 1'b0;

  always @(posedge clk) begin
    logic acc, wr, start, wdone, wovr, fin, busy, nirq;
    logic [31:0] off, rd, lm;
    started = 1'b1;
    if (!rst_n) begin
      m_phase = 0; m_irq_en = 0; m_done = 0; m_ovr = 0; m_ack = 0; m_irq = 0; m_dat = 0;
      for (int n = 0; n < NC; n++) begin m_in[n] = '0; m_out[n] = '0; end
    end else begin
      acc   = wbs_cyc_i && wbs_stb_i && !m_ack;
      wr    = acc && wbs_we_i;
      off   = wishbone_address - BASE;
      lm    = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
      busy  = (m_phase != 0);
      rd    = 0;
      if (off == 0) rd = {30'b0, m_irq_en, 1'b0};
      if (off == 4) rd = {29'b0, m_ovr, m_done, busy};
      for (int n = 0; n < NC; n++) begin
        if (off == 32'(16 + 4*n)) rd = 32'(m_in[n]);
        if (off == 32'(48 + 4*n)) rd = 32'(m_out[n]);
      end
      start = wr && off == 0 && wbs_sel_i[0] && wbs_dat_i[0];
      wdone = wr && off == 4 && wbs_sel_i[0] && wbs_dat_i[1];
      wovr  = wr && off == 4 && wbs_sel_i[0] && wbs_dat_i[2];
      fin   = (m_phase == 2) && core_rsp_valid;
      nirq  = m_irq_en && m_done;
      if (wr && off == 0 && wbs_sel_i[0]) m_irq_en = wbs_dat_i[1];
      if (fin) m_done = 1; else if (wdone) m_done = 0;
      if (start && busy) m_ovr = 1; else if (wovr) m_ovr = 0;
      for (int n = 0; n < NC; n++) begin
        if (wr && !busy && off == 32'(16 + 4*n))
          m_in[n] = DW'((32'(m_in[n]) & ~lm) | (wbs_dat_i & lm));
        if (fin) m_out[n] = core_rsp_data[n*DW +: DW];
      end
      case (m_phase)
        0: if (start) m_phase = 1;
        1: if (core_req_ready) m_phase = 2;
        default: if (core_rsp_valid) m_phase = 0;
      endcase
      m_ack = acc;
      if (acc) m_dat = rd;
      m_irq = nirq;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ack", 64'(wbs_ack_o), 64'(m_ack));
      if (m_ack) chk("rdata", 64'(wbs_dat_o), 64'(m_dat));
      chk("req_valid", 64'(core_req_valid), 64'(m_phase == 1));
      chk("irq", 64'(irq), 64'(m_irq));
      chk("core_in", 64'(core_in), 64'({m_in[1], m_in[0]}));
    end
  end

  task automatic xfer(input logic we, input logic [7:0] off, input logic [31:0] wd,
                      input logic [3:0] sel, input logic rsp_pulse,
                      output logic [31:0] rd, output int lat);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
    wishbone_address = BASE + 32'(off); wbs_sel_i = sel; wbs_dat_i = wd;
    if (rsp_pulse) core_rsp_valid = 1;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (rsp_pulse && lat == 2) core_rsp_valid = 0;
      if (wbs_ack_o) break;
    end
    if (!wbs_ack_o) begin
      checks++; errors++;
      $display("FAIL wb_timeout: no ack at offset %0h after %0d cycles", off, lat);
    end
    rd = wbs_dat_o;
    @(posedge clk); #1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] sel);
    logic [31:0] rd; int lat;
    xfer(1'b1, off, wd, sel, 1'b0, rd, lat);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] rd; int lat;
    xfer(1'b0, off, 32'h0, 4'hF, 1'b0, rd, lat);
    chk(name, 64'(rd), 64'(exp));
    chk({name, "_lat"}, 64'(lat), 64'd2);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd; int lat;
    rst_n = 0; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wishbone_address = 0; wbs_sel_i = 0; wbs_dat_i = 0;
    core_req_ready = 0; core_rsp_valid = 0; core_rsp_data = '0;
    tick(2);
    rst_n = 1;

    // Reset state
    chk("rst_irq", 64'(irq), 64'd0);
    rd_chk("rst_ctrl", 8'h00, 32'h0);
    rd_chk("rst_status", 8'h04, 32'h0);
    rd_chk("rst_in0", 8'h10, 32'h0);
    rd_chk("rst_in1", 8'h14, 32'h0);
    rd_chk("rst_out0", 8'h30, 32'h0);
    rd_chk("rst_out1", 8'h34, 32'h0);

    // Byte lanes and truncation above DATA_W
    wr(8'h10, 32'h0001_2345, 4'b0011);
    rd_chk("lane_lo", 8'h10, 32'h0000_2345);
    wr(8'h10, 32'hFFFF_FFFF, 4'b1111);
    rd_chk("lane_all", 8'h10, 32'h000F_FFFF);
    wr(8'h10, 32'h0, 4'b0100);
    rd_chk("lane_b2", 8'h10, 32'h0000_FFFF);

    // CH_OUT read-only, unmapped offsets, out-of-window address
    wr(8'h30, 32'h0000_0ABC, 4'hF);
    rd_chk("out_ro", 8'h30, 32'h0);
    wr(8'h18, 32'h1234, 4'hF);
    rd_chk("unmap_ch2", 8'h18, 32'h0);
    rd_chk("unmap_08", 8'h08, 32'h0);
    wishbone_address = 32'h3004_0010;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF; wbs_dat_i = 32'h55;
    tick(2);
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    rd_chk("out_window", 8'h10, 32'h0000_FFFF);

    // Full transaction
    wr(8'h10, 32'd5, 4'hF);
    wr(8'h14, 32'd7, 4'hF);
    wr(8'h00, 32'h2, 4'hF);
    rd_chk("ctrl_irqen", 8'h00, 32'h2);
    wr(8'h00, 32'h3, 4'hF);
    chk("req_valid_on", 64'(core_req_valid), 64'd1);
    tick(2);
    chk("core_in_lit", 64'(core_in), 64'h00_0070_0005);
    core_req_ready = 1;
    tick(1);
    core_req_ready = 0;
    chk("req_valid_off", 64'(core_req_valid), 64'd0);
    tick(3);
    core_rsp_data = {20'd8, 20'd6};
    core_rsp_valid = 1;
    tick(1);
    core_rsp_valid = 0;
    chk("irq_lag", 64'(irq), 64'd0);
    tick(1);
    chk("irq_set", 64'(irq), 64'd1);
    rd_chk("out0", 8'h30, 32'd6);
    rd_chk("out1", 8'h34, 32'd8);
    rd_chk("status_done", 8'h04, 32'h2);
    rd_chk("ctrl_start_rd0", 8'h00, 32'h2);

    // START and CH_IN write while busy
    wr(8'h04, 32'h2, 4'hF);
    rd_chk("status_clr", 8'h04, 32'h0);
    wr(8'h00, 32'h3, 4'hF);
    core_req_ready = 1;
    tick(1);
    core_req_ready = 0;
    wr(8'h00, 32'h3, 4'hF);
    wr(8'h10, 32'd9, 4'hF);
    rd_chk("status_ovr", 8'h04, 32'h5);
    rd_chk("in0_held", 8'h10, 32'd5);
    core_rsp_data = {20'h11, 20'h22};
    core_rsp_valid = 1;
    tick(1);
    core_rsp_valid = 0;
    rd_chk("status_ovr_done", 8'h04, 32'h6);
    rd_chk("out0_b", 8'h30, 32'h22);
    rd_chk("out1_b", 8'h34, 32'h11);
    wr(8'h04, 32'h6, 4'hF);
    rd_chk("status_w1c", 8'h04, 32'h0);

    // DONE set and W1C on the same edge
    wr(8'h00, 32'h3, 4'hF);
    core_req_ready = 1;
    tick(1);
    core_req_ready = 0;
    core_rsp_data = {20'h3, 20'h4};
    xfer(1'b1, 8'h04, 32'h2, 4'hF, 1'b1, rd, lat);
    rd_chk("done_wins", 8'h04, 32'h2);
    chk("irq_done_wins", 64'(irq), 64'd1);
    wr(8'h04, 32'h2, 4'hF);
    rd_chk("done_cleared", 8'h04, 32'h0);
    chk("irq_cleared", 64'(irq), 64'd0);

    // Reset while requesting abandons the transaction
    wr(8'h00, 32'h3, 4'hF);
    chk("req_before_rst", 64'(core_req_valid), 64'd1);
    rst_n = 0;
    tick(1);
    rst_n = 1;
    chk("req_after_rst", 64'(core_req_valid), 64'd0);
    core_rsp_data = {20'hAAAAA, 20'h55555};
    core_rsp_valid = 1;
    tick(1);
    core_rsp_valid = 0;
    rd_chk("rst_mid_status", 8'h04, 32'h0);
    rd_chk("rst_mid_out0", 8'h30, 32'h0);
    rd_chk("rst_mid_out1", 8'h34, 32'h0);
    rd_chk("rst_mid_ctrl", 8'h00, 32'h0);
    rd_chk("rst_mid_in0", 8'h10, 32'h0);
    chk("rst_mid_irq", 64'(irq), 64'd0);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
